// File: rtl/ir_pkg.sv
// Shared constants and types for the instruction register / decode stage.
// Opcode map, ALU operation codes, FSM encoding and instruction field widths.
package ir_pkg;

    localparam int OPC_W = 4;
    localparam int REG_W = 2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    localparam logic [7:0] ILLEGAL_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_VALID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_write;
        logic       use_imm;
        logic       is_jump;
        logic       illegal;
        logic       is_halt;
    } ctrl_t;

    // Bit offsets of each field, counted from the LSB of the instruction word.
    function automatic int opc_lsb(input int imm_w);
        return imm_w + 2 * REG_W;
    endfunction

    function automatic int rd_lsb(input int imm_w);
        return imm_w + REG_W;
    endfunction

    function automatic int rs_lsb(input int imm_w);
        return imm_w;
    endfunction

endpackage

// File: rtl/ir_opcode_lut.sv
// Combinational opcode to control-field lookup.
// Unmapped opcodes (9..E) raise only the illegal flag.
module ir_opcode_lut
    import ir_pkg::*;
(
    input  logic [3:0] opcode_i,
    output ctrl_t      ctrl_o
);

    // Opcode decode table; every control defaults to inactive.
    always_comb begin
        ctrl_o.alu_op    = ALU_PASS;
        ctrl_o.reg_write = 1'b0;
        ctrl_o.use_imm   = 1'b0;
        ctrl_o.is_jump   = 1'b0;
        ctrl_o.illegal   = 1'b0;
        ctrl_o.is_halt   = 1'b0;
        case (opcode_i)
            OP_NOP:  ctrl_o.alu_op = ALU_PASS;
            OP_LDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.use_imm   = 1'b1;
            end
            OP_ADD: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.reg_write = 1'b1;
            end
            OP_SUB: begin
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.reg_write = 1'b1;
            end
            OP_AND: begin
                ctrl_o.alu_op    = ALU_AND;
                ctrl_o.reg_write = 1'b1;
            end
            OP_OR: begin
                ctrl_o.alu_op    = ALU_OR;
                ctrl_o.reg_write = 1'b1;
            end
            OP_XOR: begin
                ctrl_o.alu_op    = ALU_XOR;
                ctrl_o.reg_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.use_imm   = 1'b1;
            end
            OP_JMP:  ctrl_o.is_jump = 1'b1;
            OP_HALT: ctrl_o.is_halt = 1'b1;
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ir_decode.sv
// Instruction register and decode stage with valid/ack handoff to execute.
// Optional saturating illegal-opcode counter: define IR_DECODE_ILLEGAL_CNT_EN.
module ir_decode
    import ir_pkg::*;
#(
    parameter  int IMM_W   = 8,
    parameter  int ADDR_W  = 8,
    localparam int INSTR_W = 8 + IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               ir_load,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               exec_ack,
    output logic [INSTR_W-1:0] ir,
    output logic               dec_valid,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [IMM_W-1:0]   imm,
    output logic [2:0]         alu_op,
    output logic               reg_write,
    output logic               use_imm,
    output logic               is_jump,
    output logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic               halt,
    output logic               illegal,
    output logic               overrun,
    output logic [7:0]         illegal_count
);

    localparam int OPC_LSB = opc_lsb(IMM_W);
    localparam int RD_LSB  = rd_lsb(IMM_W);
    localparam int RS_LSB  = rs_lsb(IMM_W);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  inst_pc_q, inst_pc_d;
    logic               dec_valid_q, dec_valid_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [1:0]         rd_q, rd_d;
    logic [1:0]         rs_q, rs_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               reg_write_q, reg_write_d;
    logic               use_imm_q, use_imm_d;
    logic               is_jump_q, is_jump_d;
    logic [ADDR_W-1:0]  jump_target_q, jump_target_d;
    logic               illegal_q, illegal_d;
    logic               halt_q, halt_d;
    logic               overrun_q, overrun_d;
    logic               load_req;
    ctrl_t              lut_ctrl;
`ifdef IR_DECODE_ILLEGAL_CNT_EN
    logic [7:0]         cnt_q, cnt_d;
`endif

    ir_opcode_lut u_lut (
        .opcode_i (ir_q[OPC_LSB +: OPC_W]),
        .ctrl_o   (lut_ctrl)
    );

    // A halted core never accepts new words, so load requests collapse to 0.
    assign load_req = ir_load & ~halt_q;

    // Next-state and next-output logic for the load/decode/valid sequence.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        inst_pc_d     = inst_pc_q;
        dec_valid_d   = dec_valid_q;
        opcode_d      = opcode_q;
        rd_d          = rd_q;
        rs_d          = rs_q;
        imm_d         = imm_q;
        alu_op_d      = alu_op_q;
        reg_write_d   = reg_write_q;
        use_imm_d     = use_imm_q;
        is_jump_d     = is_jump_q;
        jump_target_d = jump_target_q;
        illegal_d     = illegal_q;
        halt_d        = halt_q;
        overrun_d     = overrun_q;
`ifdef IR_DECODE_ILLEGAL_CNT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    ir_d      = rom_data;
                    inst_pc_d = pc;
                    state_d   = ST_LOADED;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOADED: begin
                opcode_d      = ir_q[OPC_LSB +: OPC_W];
                rd_d          = ir_q[RD_LSB +: REG_W];
                rs_d          = ir_q[RS_LSB +: REG_W];
                imm_d         = ir_q[IMM_W-1:0];
                jump_target_d = ir_q[ADDR_W-1:0];
                alu_op_d      = lut_ctrl.alu_op;
                reg_write_d   = lut_ctrl.reg_write;
                use_imm_d     = lut_ctrl.use_imm;
                is_jump_d     = lut_ctrl.is_jump;
                illegal_d     = lut_ctrl.illegal;
                dec_valid_d   = 1'b1;
                state_d       = ST_VALID;
                if (lut_ctrl.is_halt) begin
                    halt_d = 1'b1;
                end else begin
                    halt_d = halt_q;
                end
                if (load_req) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
`ifdef IR_DECODE_ILLEGAL_CNT_EN
                if (lut_ctrl.illegal && (cnt_q != ILLEGAL_CNT_MAX)) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
`endif
            end
            ST_VALID: begin
                if (exec_ack) begin
                    dec_valid_d = 1'b0;
                    // Ack and load together hand over without an idle bubble.
                    if (load_req) begin
                        ir_d      = rom_data;
                        inst_pc_d = pc;
                        state_d   = ST_LOADED;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else if (load_req) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = ST_VALID;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                dec_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ir_q          <= '0;
            inst_pc_q     <= '0;
            dec_valid_q   <= 1'b0;
            opcode_q      <= 4'd0;
            rd_q          <= 2'd0;
            rs_q          <= 2'd0;
            imm_q         <= '0;
            alu_op_q      <= 3'd0;
            reg_write_q   <= 1'b0;
            use_imm_q     <= 1'b0;
            is_jump_q     <= 1'b0;
            jump_target_q <= '0;
            illegal_q     <= 1'b0;
            halt_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef IR_DECODE_ILLEGAL_CNT_EN
            cnt_q         <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            inst_pc_q     <= inst_pc_d;
            dec_valid_q   <= dec_valid_d;
            opcode_q      <= opcode_d;
            rd_q          <= rd_d;
            rs_q          <= rs_d;
            imm_q         <= imm_d;
            alu_op_q      <= alu_op_d;
            reg_write_q   <= reg_write_d;
            use_imm_q     <= use_imm_d;
            is_jump_q     <= is_jump_d;
            jump_target_q <= jump_target_d;
            illegal_q     <= illegal_d;
            halt_q        <= halt_d;
            overrun_q     <= overrun_d;
`ifdef IR_DECODE_ILLEGAL_CNT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign ir          = ir_q;
    assign inst_pc     = inst_pc_q;
    assign dec_valid   = dec_valid_q;
    assign opcode      = opcode_q;
    assign rd          = rd_q;
    assign rs          = rs_q;
    assign imm         = imm_q;
    assign alu_op      = alu_op_q;
    assign reg_write   = reg_write_q;
    assign use_imm     = use_imm_q;
    assign is_jump     = is_jump_q;
    assign jump_target = jump_target_q;
    assign illegal     = illegal_q;
    assign halt        = halt_q;
    assign overrun     = overrun_q;
`ifdef IR_DECODE_ILLEGAL_CNT_EN
    assign illegal_count = cnt_q;
`else
    assign illegal_count = 8'd0;
`endif

endmodule

// File: tb/tb_ir_decode.sv
// Self-checking bench for ir_decode: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_ir_decode;

    localparam int IMM_W   = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8 + IMM_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [INSTR_W-1:0] rom_data = '0;
    logic               ir_load = 1'b0;
    logic [ADDR_W-1:0]  pc = '0;
    logic               exec_ack = 1'b0;
    logic [INSTR_W-1:0] ir;
    logic               dec_valid;
    logic [3:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [IMM_W-1:0]   imm;
    logic [2:0]         alu_op;
    logic               reg_write;
    logic               use_imm;
    logic               is_jump;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  inst_pc;
    logic               halt;
    logic               illegal;
    logic               overrun;
    logic [7:0]         illegal_count;

    int n_cmp = 0;
    int n_bad = 0;

    ir_decode #(.IMM_W(IMM_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rom_data(rom_data), .ir_load(ir_load),
        .pc(pc), .exec_ack(exec_ack), .ir(ir), .dec_valid(dec_valid),
        .opcode(opcode), .rd(rd), .rs(rs), .imm(imm), .alu_op(alu_op),
        .reg_write(reg_write), .use_imm(use_imm), .is_jump(is_jump),
        .jump_target(jump_target), .inst_pc(inst_pc), .halt(halt),
        .illegal(illegal), .overrun(overrun), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Model: an instruction is held with an age (1 = just captured, 2 = decode visible).
    bit                 m_have = 1'b0;
    int                 m_age = 0;
    logic [INSTR_W-1:0] m_ir = '0;
    logic [ADDR_W-1:0]  m_pc = '0;
    bit                 m_halt = 1'b0;
    bit                 m_overrun = 1'b0;
    int                 m_cnt = 0;

    // Returns {alu_op[2:0], reg_write, use_imm, is_jump, illegal, is_halt}.
    function automatic logic [7:0] mdec(input logic [3:0] op);
        logic [2:0] a = 3'd0;
        logic rw = 1'b0, ui = 1'b0, j = 1'b0, il = 1'b0, h = 1'b0;
        int o = int'(op);
        if (o >= 2 && o <= 6) begin a = 3'(o - 1); rw = 1'b1; end
        else if (o == 1) begin rw = 1'b1; ui = 1'b1; end
        else if (o == 7) begin a = 3'd1; rw = 1'b1; ui = 1'b1; end
        else if (o == 8) j = 1'b1;
        else if (o == 15) h = 1'b1;
        else if (o != 0) il = 1'b1;
        return {a, rw, ui, j, il, h};
    endfunction

    task automatic model_step();
        bit valid, loaded, accept;
        logic [7:0] d;
        if (reset) begin
            m_have = 1'b0; m_age = 0; m_ir = '0; m_pc = '0;
            m_halt = 1'b0; m_overrun = 1'b0; m_cnt = 0;
            return;
        end
        valid  = m_have && (m_age >= 2);
        loaded = m_have && (m_age == 1);
        accept = ir_load && !m_halt && (!m_have || (valid && exec_ack));
        if (ir_load && !m_halt && (loaded || (valid && !exec_ack))) m_overrun = 1'b1;
        if (valid && exec_ack) m_have = 1'b0;
        if (loaded) begin
            m_age = 2;
            d = mdec(m_ir[INSTR_W-1 -: 4]);
            if (d[0]) m_halt = 1'b1;
`ifdef IR_DECODE_ILLEGAL_CNT_EN
            if (d[1] && m_cnt < 255) m_cnt++;
`endif
        end
        if (accept) begin
            m_have = 1'b1; m_age = 1; m_ir = rom_data; m_pc = pc;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, on the falling edge.
    initial forever begin
        logic [7:0] d;
        @(negedge clk);
        chk("ir", 32'(ir), 32'(m_ir));
        chk("inst_pc", 32'(inst_pc), 32'(m_pc));
        chk("dec_valid", 32'(dec_valid), 32'(m_have && m_age >= 2));
        chk("halt", 32'(halt), 32'(m_halt));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
        if (m_have && m_age >= 2) begin
            d = mdec(m_ir[INSTR_W-1 -: 4]);
            chk("opcode", 32'(opcode), 32'(m_ir[INSTR_W-1 -: 4]));
            chk("rd", 32'(rd), 32'(m_ir[IMM_W+3 -: 2]));
            chk("rs", 32'(rs), 32'(m_ir[IMM_W+1 -: 2]));
            chk("imm", 32'(imm), 32'(m_ir[IMM_W-1:0]));
            chk("jump_target", 32'(jump_target), 32'(m_ir[ADDR_W-1:0]));
            chk("alu_op", 32'(alu_op), 32'(d[7:5]));
            chk("reg_write", 32'(reg_write), 32'(d[4]));
            chk("use_imm", 32'(use_imm), 32'(d[3]));
            chk("is_jump", 32'(is_jump), 32'(d[2]));
            chk("illegal", 32'(illegal), 32'(d[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [INSTR_W-1:0] w, input logic [ADDR_W-1:0] p);
        rom_data = w; pc = p; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        step();
    endtask

    task automatic ack();
        exec_ack = 1'b1;
        step();
        exec_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_cnt", 32'(illegal_count), 32'd0);
        reset = 1'b0;

        // LDI rd=2 imm=5 at pc 3
        rom_data = 16'h1A05; pc = 8'd3; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        chk("ldi_ir", 32'(ir), 32'h1A05);
        chk("ldi_early_valid", 32'(dec_valid), 32'd0);
        step();
        chk("ldi_valid", 32'(dec_valid), 32'd1);
        chk("ldi_reg_write", 32'(reg_write), 32'd1);
        chk("ldi_use_imm", 32'(use_imm), 32'd1);
        chk("ldi_alu_op", 32'(alu_op), 32'd0);
        chk("ldi_rd", 32'(rd), 32'd2);
        chk("ldi_imm", 32'(imm), 32'h05);
        chk("ldi_inst_pc", 32'(inst_pc), 32'd3);
        step(); step();
        chk("ldi_hold", 32'(dec_valid), 32'd1);
        ack();
        chk("ldi_fall", 32'(dec_valid), 32'd0);

        load_word(16'h8042, 8'h10);
        chk("jmp_is_jump", 32'(is_jump), 32'd1);
        chk("jmp_target", 32'(jump_target), 32'h42);
        chk("jmp_reg_write", 32'(reg_write), 32'd0);
        ack();

        load_word(16'hB000, 8'h11);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_controls", 32'({reg_write, use_imm, is_jump, alu_op}), 32'd0);
        ack();

        // Overrun: second load while VALID and not acked.
        load_word(16'h2400, 8'h20);
        rom_data = 16'h3500; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_ir_kept", 32'(ir), 32'h2400);
        ack();
        do_reset();
        load_word(16'h2400, 8'h21);
        rom_data = 16'h3500; pc = 8'h22; ir_load = 1'b1; exec_ack = 1'b1;
        step();
        ir_load = 1'b0; exec_ack = 1'b0;
        chk("handover_ir", 32'(ir), 32'h3500);
        chk("handover_ovr", 32'(overrun), 32'd0);
        chk("handover_bubble", 32'(dec_valid), 32'd0);
        step();
        chk("handover_alu", 32'(alu_op), 32'd2);
        ack();

        // HALT is sticky and blocks loads without flagging overrun.
        load_word(16'hF000, 8'h30);
        chk("halt_set", 32'(halt), 32'd1);
        ack();
        rom_data = 16'h1111; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        step();
        chk("halt_ir_kept", 32'(ir), 32'hF000);
        chk("halt_no_ovr", 32'(overrun), 32'd0);
        chk("halt_no_valid", 32'(dec_valid), 32'd0);
        do_reset();
        chk("halt_cleared", 32'(halt), 32'd0);

        // Reset while LOADED.
        rom_data = 16'h1A05; pc = 8'h40; ir_load = 1'b1;
        step();
        ir_load = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_ir", 32'(ir), 32'd0);
        chk("rstmid_pc", 32'(inst_pc), 32'd0);
        step();
        chk("rstmid_valid", 32'(dec_valid), 32'd0);

        // Illegal counter saturation.
        for (int i = 0; i < 260; i++) begin
            load_word({4'(9 + $urandom_range(0, 5)), 12'($urandom)}, 8'(i));
            ack();
        end
`ifdef IR_DECODE_ILLEGAL_CNT_EN
        chk("cnt_saturate", 32'(illegal_count), 32'd255);
`else
        chk("cnt_absent", 32'(illegal_count), 32'd0);
`endif
        do_reset();

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            rom_data = 16'($urandom);
            pc       = 8'($urandom);
            ir_load  = ($urandom_range(0, 9) < 4);
            exec_ack = ($urandom_range(0, 9) < 4);
            reset    = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0; ir_load = 1'b0; exec_ack = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ir_decode.md
Name: ir_decode

Overview:
Instruction register and decode stage sitting directly downstream of the fetch/decode/execute control FSM and the instruction ROM. Captures the ROM word when the FSM pulses ir_load, decodes it into registered control fields, and holds them under a valid/ack handshake until the execute datapath consumes them. Also tracks a sticky HALT condition and flags illegal opcodes and handshake overruns.

Parameters:
IMM_W, 8, immediate field width; instruction width INSTR_W = 8 + IMM_W (opcode 4, rd 2, rs 2, imm IMM_W)
ADDR_W, 8, pc / jump-target width; must be <= IMM_W

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rom_data  in  INSTR_W  ROM output word, valid the cycle ir_load is high
ir_load  in  1  capture strobe from control FSM
pc  in  ADDR_W  pc of the instruction being loaded
exec_ack  in  1  execute stage consumed current decode
ir  out  INSTR_W  instruction register
dec_valid  out  1  decoded fields valid
opcode  out  4  ir[INSTR_W-1:INSTR_W-4]
rd  out  2  destination register
rs  out  2  source register
imm  out  IMM_W  immediate field
alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
reg_write  out  1  destination write enable
use_imm  out  1  ALU operand B is imm
is_jump  out  1  unconditional jump
jump_target  out  ADDR_W  imm[ADDR_W-1:0]
inst_pc  out  ADDR_W  pc captured with the instruction
halt  out  1  sticky halt
illegal  out  1  current decode is an illegal opcode
overrun  out  1  sticky: ir_load arrived while dec_valid and no exec_ack
illegal_count  out  8  saturating illegal-opcode counter (see Optional Feature)

Behaviour:
- Reset (sync, active-high): every output 0; state IDLE; ir = 0.
- States: IDLE -> (ir_load & !halt) -> LOADED -> VALID -> (exec_ack) -> IDLE.
- IDLE + ir_load: ir <= rom_data, inst_pc <= pc. LOADED: decode fields registered. VALID: dec_valid = 1. Latency: ir valid 1 cycle after ir_load; dec_valid 2 cycles after ir_load.
- dec_valid and all decoded fields hold stable in VALID until exec_ack is sampled high; dec_valid falls the following cycle. exec_ack outside VALID is ignored.
- ir_load in LOADED, or in VALID without exec_ack: load ignored, overrun set (sticky to reset). ir_load and exec_ack in the same VALID cycle: accepted, go straight to LOADED with the new word.
- Opcode map: 0 NOP (no controls); 1 LDI (reg_write, use_imm, PASS); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (2-6 reg_write, rs operand); 7 ADDI (reg_write, use_imm, ADD); 8 JMP (is_jump); F HALT; 9-E illegal (illegal = 1, all other controls 0).
- HALT: halt sets when the HALT decode reaches VALID and is sticky until reset; ir_load ignored while halt (no overrun).
- Reset mid-operation: returns to IDLE in one cycle; pending decode discarded.

Optional Feature:
Macro IR_DECODE_ILLEGAL_CNT_EN. Defined: illegal_count increments once per illegal decode entering VALID, saturates at 255, clears on reset. Undefined: illegal_count tied to 0, no counter flops.

Decomposition:
- Package ir_pkg: opcode constants (OP_NOP..OP_HALT), alu_op constants (ALU_PASS..ALU_XOR), state encoding (ST_IDLE, ST_LOADED, ST_VALID), field offsets.
- One sub-module ir_opcode_lut: pure combinational opcode -> {alu_op, reg_write, use_imm, is_jump, illegal, is_halt}; ir_decode registers its outputs.

Test Plan:
- Reset then ir_load with rom_data=16'h1A05 (LDI rd=2 imm=5), pc=3 -> 2 cycles later dec_valid=1, reg_write=1, use_imm=1, alu_op=0, rd=2, imm=8'h05, inst_pc=3; held until exec_ack, dec_valid=0 the cycle after.
- rom_data=16'h8042 (JMP) -> is_jump=1, jump_target=8'h42, reg_write=0.
- rom_data=16'hB000 -> illegal=1, all other controls 0; with IR_DECODE_ILLEGAL_CNT_EN, 260 illegal loads -> illegal_count=255.
- Second ir_load during VALID without exec_ack -> overrun=1, ir unchanged; with exec_ack same cycle -> new word accepted, overrun stays 0.
- rom_data=16'hF000 -> halt=1; subsequent ir_load ignored, ir unchanged, overrun 0; reset -> halt=0.
- Reset asserted in LOADED -> next cycle all outputs 0, state IDLE.
